mem_responder: RTL and testbench

- Memory-side responder for the CPU's data/instruction port: accepts one request at a time and performs word or byte-lane writes, or word reads.
- Internal word-organised storage array with a configurable number of wait states.
- Answers each request with a one-cycle Ready pulse and an address-error flag.
- Replaces the zero-latency memory so the control unit can be exercised against a handshaked, multi-cycle memory.

---
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: handshaked, multi-cycle word memory for the CPU data/instruction port.
// It accepts one request at a time. A valid request spends WAIT_STATES+1 cycles in WAIT,
// then raises Ready for one cycle. A rejected request answers after one cycle with AddrErr.
// Optional feature macro: MEM_WRITE_READBACK_EN. When it is defined, a valid write also
// loads the merged word into Dataout.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [3:0]  ByteEn,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;

  // Request registers. They are captured at acceptance so that later input changes
  // cannot disturb the request in flight.
  logic                    req_wr;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [3:0]              req_be;
  logic [31:0]             req_data;

  logic [31:0]             mem [DEPTH];

  logic                    addr_bad;
  logic                    commit;
  logic [31:0]             merged_word;

  // Replace only the enabled byte lanes of the old word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
    end
    return w;
  endfunction

  // The error check looks at the request presented at acceptance. Bits above the array
  // span must be zero. A full-word access must also be word aligned.
  always_comb begin
    addr_bad = (Address[31:DEPTH_LOG2+2] != '0) ||
               ((ByteEn == 4'b1111) && (Address[1:0] != 2'b00));
  end

  // The commit happens on the last WAIT cycle, when the counter has run down to zero.
  always_comb begin
    commit      = (state == WAIT) && (wait_cnt == 4'd0);
    merged_word = merge_lanes(mem[req_idx], req_data, req_be);
  end

  // Capture the request fields on the accepting edge.
  always_ff @(posedge Clk) begin
    if (state == IDLE && Req) begin
      req_wr   <= Wr;
      req_idx  <= Address[DEPTH_LOG2+1:2];
      req_be   <= ByteEn;
      req_data <= Datain;
    end
  end

  // Storage array. It has no reset. An aborted request never reaches this write,
  // because reset forces the state out of WAIT.
  always_ff @(posedge Clk) begin
    if (commit && req_wr) mem[req_idx] <= merged_word;
  end

  // Control FSM with registered Ready/Busy/AddrErr/Dataout.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      Dataout  <= 32'd0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      AddrErr  <= 1'b0;
    end else begin
      Ready   <= 1'b0;
      AddrErr <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            Busy <= 1'b1;
            if (addr_bad) begin
              state   <= RESP;
              Ready   <= 1'b1;
              AddrErr <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
            Ready <= 1'b1;
`ifdef MEM_WRITE_READBACK_EN
            Dataout <= req_wr ? merged_word : mem[req_idx];
`else
            if (!req_wr) Dataout <= mem[req_idx];
`endif
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Each request pushes its expected response onto a
// scoreboard queue. A monitor pops the queue on every Ready and checks Dataout,
// AddrErr and latency against it.
module tb_mem_responder;

  localparam int DL = 8;
  localparam int W  = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        ready;
  logic        busy;
  logic        addr_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [1 << DL];
  logic [31:0] model_dout;
  int          cyc;
  int          n_cmp;
  int          n_err;

  mem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(W)) dut (
    .Clk     (clk),
    .Reset   (rst),
    .Req     (req),
    .Wr      (wr),
    .Address (address),
    .ByteEn  (byte_en),
    .Datain  (datain),
    .Dataout (dataout),
    .Ready   (ready),
    .Busy    (busy),
    .AddrErr (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a, input logic [3:0] be);
    return (a[31:DL+2] != '0) || ((be == 4'hF) && (a[1:0] != 2'b00));
  endfunction

  // Monitor: every Ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("dataout", dataout, e.data);
        check_eq("addrerr", {31'd0, addr_err}, {31'd0, e.err});
        check_eq("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Update the model and return the expected response for one request.
  // The caller drives the request pins itself.
  task automatic model_req(input logic w_en, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] data, output exp_t e);
    logic [31:0] w;
    e.start = cyc;
    e.err   = is_bad(addr, be);
    if (e.err) begin
      e.lat = 1;
    end else begin
      e.lat = W + 2;
      if (w_en) begin
        w = model_mem[addr[DL+1:2]];
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
        model_mem[addr[DL+1:2]] = w;
`ifdef MEM_WRITE_READBACK_EN
        model_dout = w;
`endif
      end else begin
        model_dout = model_mem[addr[DL+1:2]];
      end
    end
    e.data = model_dout;
  endtask

  task automatic issue_req(input logic w_en, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] data);
    exp_t e;
    @(negedge clk);
    wr = w_en; address = addr; byte_en = be; datain = data; req = 1'b1;
    model_req(w_en, addr, be, data, e);
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    datain = ~data;
    address = 32'hFFFF_FFFF;
    wait_drain();
  endtask

  initial begin
    logic [31:0] held_addr [4];
    exp_t        e;
    int          k;
    int          n;

    n_cmp = 0; n_err = 0; cyc = 0;
    model_dout = 32'd0;
    rst = 1'b0; req = 1'b0; wr = 1'b0; address = '0; byte_en = '0; datain = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_dataout", dataout, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_addrerr", {31'd0, addr_err}, 32'd0);
    rst = 1'b0;

    // Full-word writes and reads, then a single-lane merge
    issue_req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    issue_req(1'b0, 32'h10, 4'hF, 32'h0);
    issue_req(1'b1, 32'h20, 4'hF, 32'h1111_2222);
    issue_req(1'b1, 32'h10, 4'b0010, 32'h0000_AA00);
    issue_req(1'b0, 32'h10, 4'h0, 32'h0);

    // Misaligned full-word write is rejected and leaves the array alone
    issue_req(1'b1, 32'h12, 4'hF, 32'h0BAD_0BAD);
    issue_req(1'b0, 32'h10, 4'h0, 32'h0);

    // An empty lane mask completes without changing the word
    issue_req(1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF);
    issue_req(1'b0, 32'h10, 4'h0, 32'h0);

    // Range boundary: the last word is valid, the first word past the end is rejected
    issue_req(1'b1, 32'h3FC, 4'hF, 32'h55AA_33CC);
    issue_req(1'b0, 32'h400, 4'h0, 32'h0);
    issue_req(1'b0, 32'h3FC, 4'h0, 32'h0);
    issue_req(1'b0, 32'h3FF, 4'h0, 32'h0);
    issue_req(1'b0, 32'h8000_0010, 4'h0, 32'h0);

    // Reset in WAIT aborts the write
    @(negedge clk);
    wr = 1'b1; address = 32'h20; byte_en = 4'hF; datain = 32'h1234_5678; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check_eq("busy_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_ready", {31'd0, ready}, 32'd0);
    check_eq("abort_dataout", dataout, 32'd0);
    model_dout = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    issue_req(1'b0, 32'h20, 4'h0, 32'h0);

    // Reset in RESP: the write has already committed, and Ready drops at once
    @(negedge clk);
    wr = 1'b1; address = 32'h30; byte_en = 4'hF; datain = 32'hA5A5_5A5A; req = 1'b1;
    model_req(1'b1, 32'h30, 4'hF, 32'hA5A5_5A5A, e);
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("resp_seen", {31'd0, ready}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("resp_rst_ready", {31'd0, ready}, 32'd0);
    check_eq("resp_rst_busy", {31'd0, busy}, 32'd0);
    model_dout = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    wait_drain();
    issue_req(1'b0, 32'h30, 4'h0, 32'h0);

    // Req held high: one acceptance every W+3 cycles, no request lost
    held_addr[0] = 32'h10; held_addr[1] = 32'h20;
    held_addr[2] = 32'h30; held_addr[3] = 32'h3FC;
    @(negedge clk);
    k = cyc;
    wr = 1'b0; byte_en = 4'h0; datain = 32'h0; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      while (cyc != k + (W + 3) * i) @(negedge clk);
      address = held_addr[i];
      model_req(1'b0, held_addr[i], 4'h0, 32'h0, e);
      sb.push_back(e);
    end
    while (cyc != k + (W + 3) * 3 + 1) @(negedge clk);
    req = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);

    // Write response: Dataout shows the merged word when readback is built in,
    // and otherwise keeps its previous value
    issue_req(1'b1, 32'h40, 4'hF, 32'hCAFE_F00D);
    issue_req(1'b0, 32'h40, 4'h0, 32'h0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
